// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: shared ALU definitions used by the HI/LO controller.
//   - function codes (6-bit) for MFHI/MTHI/MFLO/MTLO/MULTU/DIVU
//   - sequencing state enum for hilo_ctrl
//   - cnt_width(): width of the latency down-counter for two unit latencies
package hilo_ctrl_pkg;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MUL = 2'd1,
    ST_WAIT_DIV = 2'd2
  } hilo_state_e;

  // The counter is loaded with latency-1, so clog2 of the larger latency
  // is enough; never let it collapse to zero bits when both latencies are 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/hilo_ctrl_latency_counter.sv
// latency_counter: loadable down-counter that stops at zero.
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over en)
//   load_val   : value to load
//   en         : decrement by one while non-zero
//   zero       : count is currently zero
module latency_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO result registers and MULTU/DIVU sequencing.
//   clk, reset : clock, synchronous active-high reset
//   Signal     : 6-bit function code, qualified by start
//   start      : command strobe (one cycle)
//   dataIn     : MTHI/MTLO source operand
//   mulOut     : multiplier result {hi, lo}
//   divOut     : divider result {remainder, quotient}
//   dataOut    : registered MFHI/MFLO read data
//   busy       : an operation is in flight (state != IDLE)
//   done       : one-cycle pulse after HI/LO were loaded from a unit
//
// Handshake: a command is taken on a rising edge where start=1 and busy=0.
// With busy=1 the command is dropped, not queued; the control unit must
// hold it until busy returns to 0. busy/done are decoded from registers.
// The state register (state, type hilo_state_e) is the FSM observation point.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic        start,
  input  logic [31:0] dataIn,
  input  logic [63:0] mulOut,
  input  logic [63:0] divOut,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  hilo_state_e      state, state_n;
  logic [31:0]      hi, lo;
  logic             ctr_load;
  logic [CNT_W-1:0] ctr_val;
  logic             cnt_zero;
  logic             wr_hi, wr_lo, rd_hi, rd_lo;
  logic             ld_mul, ld_div;

  assign busy = (state != ST_IDLE);

  // Counter only runs in the wait states; the launch load takes priority
  // and happens from IDLE, where en is low anyway.
  latency_counter #(.W(CNT_W)) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (ctr_val),
    .en       (busy),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n  = state;
    ctr_load = 1'b0;
    ctr_val  = '0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    rd_hi    = 1'b0;
    rd_lo    = 1'b0;
    ld_mul   = 1'b0;
    ld_div   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (Signal)
            FN_MULTU: begin
              state_n  = ST_WAIT_MUL;
              ctr_load = 1'b1;
              ctr_val  = MUL_LOAD;
            end
            FN_DIVU: begin
              state_n  = ST_WAIT_DIV;
              ctr_load = 1'b1;
              ctr_val  = DIV_LOAD;
            end
            FN_MTHI: wr_hi = 1'b1;
            FN_MTLO: wr_lo = 1'b1;
            FN_MFHI: rd_hi = 1'b1;
            FN_MFLO: rd_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_WAIT_MUL: begin
        if (cnt_zero) begin
          ld_mul  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_WAIT_DIV: begin
        if (cnt_zero) begin
          ld_div  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      hi      <= '0;
      lo      <= '0;
      dataOut <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= ld_mul | ld_div;
      // Unit loads and MT writes are mutually exclusive by state.
      if (ld_mul) begin
        {hi, lo} <= mulOut;
      end else if (ld_div) begin
        {hi, lo} <= divOut;
      end else begin
        if (wr_hi) hi <= dataIn;
        if (wr_lo) lo <= dataIn;
      end
      if (rd_hi) begin
        dataOut <= hi;
      end else if (rd_lo) begin
        dataOut <= lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int MUL_N = 32;
  localparam int DIV_N = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  sig;
  logic        start;
  logic [31:0] data_in;
  logic [63:0] mul_out;
  logic [63:0] div_out;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  hilo_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .Signal  (sig),
    .start   (start),
    .dataIn  (data_in),
    .mulOut  (mul_out),
    .divOut  (div_out),
    .dataOut (data_out),
    .busy    (busy),
    .done    (done)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m, lo_m, dout_m;
  logic [31:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] c, input logic [31:0] d);
    sig     = c;
    data_in = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
    sig     = 6'd0;
    data_in = $urandom;
  endtask

  task automatic read_reg(input logic [5:0] c, output logic [31:0] v);
    issue(c, 32'd0);
    v = data_out;
  endtask

  // Launch an operation and follow it until busy drops (bounded).
  // cycles = number of edges after launch until busy=0.
  task automatic run_op(input logic [5:0] c, input logic [63:0] res,
                        output int cycles, output logic done_end,
                        output logic done_early);
    if (c == FN_MULTU) begin
      mul_out = res;
      div_out = {$urandom, $urandom};
    end else begin
      div_out = res;
      mul_out = {$urandom, $urandom};
    end
    issue(c, $urandom);
    cycles     = 0;
    done_early = 1'b0;
    while (busy && cycles < 200) begin
      if (done) done_early = 1'b1;
      step();
      cycles++;
    end
    done_end = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; start = 1'b0; sig = 6'd0; data_in = '0;
    mul_out = '0; div_out = '0;
    step(); step();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_dataout: got %h expected 0", data_out); end
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi: got %h expected 0", v); end
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mflo: got %h expected 0", v); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle_flags: got busy=%b done=%b expected 0/0", busy, done); end
    hi_m = '0; lo_m = '0; dout_m = '0;
  endtask

  task automatic test_div_basic();
    int cyc; logic de, dearly; logic [31:0] v;
    // 100 / 7 = 14 rem 2
    run_op(FN_DIVU, {32'd100 % 32'd7, 32'd100 / 32'd7}, cyc, de, dearly);
    n_checks++; if (cyc != DIV_N) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected %0d", cyc, DIV_N); end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL div_done_pulse: got %b expected 1", de); end
    n_checks++; if (dearly !== 1'b0) begin n_fail++; $display("FAIL div_done_early: got %b expected 0", dearly); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL div_done_clears: got %b expected 0", done); end
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL div_mfhi: got %h expected 2", v); end
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== 32'd14) begin n_fail++; $display("FAIL div_mflo: got %h expected 14", v); end
    hi_m = 32'd2; lo_m = 32'd14; dout_m = 32'd14;
  endtask

  task automatic test_mul();
    int cyc; logic de, dearly; logic [31:0] v; logic [63:0] p;
    p = 64'(32'hFFFF_FFFF) * 64'd2;
    run_op(FN_MULTU, p, cyc, de, dearly);
    n_checks++; if (cyc != MUL_N) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected %0d", cyc, MUL_N); end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL mul_done_pulse: got %b expected 1", de); end
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_mfhi: got %h expected 00000001", v); end
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_mflo: got %h expected fffffffe", v); end
    hi_m = 32'h1; lo_m = 32'hFFFF_FFFE; dout_m = lo_m;
  endtask

  task automatic test_mt_mf();
    logic [31:0] v;
    issue(FN_MTHI, 32'hDEAD_BEEF);
    issue(FN_MTLO, 32'h1234_5678);
    hi_m = 32'hDEAD_BEEF; lo_m = 32'h1234_5678;
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== hi_m) begin n_fail++; $display("FAIL mt_mf_hi: got %h expected %h", v, hi_m); end
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== lo_m) begin n_fail++; $display("FAIL mt_mf_lo: got %h expected %h", v, lo_m); end
    dout_m = lo_m;
    // dataOut holds across idle cycles and non-command codes
    step(); step();
    issue(6'd5, 32'hFFFF_0000);
    issue(6'd63, 32'h0000_FFFF);
    n_checks++; if (data_out !== dout_m) begin n_fail++; $display("FAIL dataout_hold: got %h expected %h", data_out, dout_m); end
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== hi_m) begin n_fail++; $display("FAIL noop_keeps_hi: got %h expected %h", v, hi_m); end
    dout_m = hi_m;
  endtask

  task automatic test_mt_during_busy();
    int edges; logic [31:0] a, b, v;
    a = $urandom; b = $urandom_range(1, 1000);
    div_out = {a % b, a / b};
    issue(FN_DIVU, 32'd0);
    edges = 1;
    repeat (5) begin step(); edges++; end
    issue(FN_MTLO, 32'hAAAA_5555); edges++;
    issue(FN_MFHI, 32'd0); edges++;
    n_checks++; if (data_out !== dout_m) begin n_fail++; $display("FAIL mf_ignored_busy: got %h expected %h", data_out, dout_m); end
    while (busy && edges < 200) begin step(); edges++; end
    n_checks++; if (edges != DIV_N + 1) begin n_fail++; $display("FAIL busy_op_length: got %0d expected %0d", edges - 1, DIV_N); end
    hi_m = a % b; lo_m = a / b;
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== lo_m) begin n_fail++; $display("FAIL mt_ignored_busy_lo: got %h expected %h", v, lo_m); end
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== hi_m) begin n_fail++; $display("FAIL mt_ignored_busy_hi: got %h expected %h", v, hi_m); end
    dout_m = hi_m;
  endtask

  task automatic test_reset_mid_op();
    int cyc; logic de, dearly, seen; logic [31:0] v, a, b;
    issue(FN_MTHI, 32'h5555_0001);
    issue(FN_MTLO, 32'h5555_0002);
    div_out = {$urandom, $urandom};
    issue(FN_DIVU, 32'd0);
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
    seen = 1'b0;
    repeat (40) begin step(); if (done || busy) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_stale_done: got %b expected 0", seen); end
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_hi: got %h expected 0", v); end
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL midreset_lo: got %h expected 0", v); end
    a = $urandom; b = $urandom_range(1, 65535);
    run_op(FN_DIVU, {a % b, a / b}, cyc, de, dearly);
    n_checks++; if (cyc != DIV_N || de !== 1'b1) begin n_fail++; $display("FAIL midreset_next_div: got cycles=%0d done=%b expected %0d/1", cyc, de, DIV_N); end
    hi_m = a % b; lo_m = a / b;
    step();
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== lo_m) begin n_fail++; $display("FAIL midreset_next_lo: got %h expected %h", v, lo_m); end
    dout_m = lo_m;
  endtask

  task automatic test_back_to_back();
    int cyc; logic de, dearly; logic [31:0] v, a, b;
    a = $urandom; b = $urandom_range(1, 300);
    run_op(FN_DIVU, {a % b, a / b}, cyc, de, dearly);
    // MFLO in the done cycle sees the freshly loaded quotient
    read_reg(FN_MFLO, v);
    n_checks++; if (v !== a / b) begin n_fail++; $display("FAIL done_cycle_mflo: got %h expected %h", v, a / b); end
    a = $urandom; b = $urandom_range(1, 300);
    run_op(FN_DIVU, {a % b, a / b}, cyc, de, dearly);
    a = $urandom; b = $urandom_range(1, 300);
    // second launch in the done cycle of the previous one
    run_op(FN_DIVU, {a % b, a / b}, cyc, de, dearly);
    n_checks++; if (cyc != DIV_N) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", cyc, DIV_N); end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", de); end
    hi_m = a % b; lo_m = a / b;
    read_reg(FN_MFHI, v);
    n_checks++; if (v !== hi_m) begin n_fail++; $display("FAIL b2b_mfhi: got %h expected %h", v, hi_m); end
    dout_m = hi_m;
  endtask

  task automatic test_random();
    int cyc; logic de, dearly; logic [31:0] v, a, b, e; logic [63:0] p;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 6))
        0: begin a = $urandom; issue(FN_MTHI, a); hi_m = a; end
        1: begin a = $urandom; issue(FN_MTLO, a); lo_m = a; end
        2: begin
          exp_q.push_back(hi_m);
          read_reg(FN_MFHI, v);
          e = exp_q.pop_front();
          n_checks++; if (v !== e) begin n_fail++; $display("FAIL rand_mfhi[%0d]: got %h expected %h", i, v, e); end
          dout_m = e;
        end
        3: begin
          exp_q.push_back(lo_m);
          read_reg(FN_MFLO, v);
          e = exp_q.pop_front();
          n_checks++; if (v !== e) begin n_fail++; $display("FAIL rand_mflo[%0d]: got %h expected %h", i, v, e); end
          dout_m = e;
        end
        4: begin
          a = $urandom; b = $urandom;
          p = 64'(a) * 64'(b);
          run_op(FN_MULTU, p, cyc, de, dearly);
          n_checks++; if (cyc != MUL_N || de !== 1'b1 || dearly !== 1'b0) begin n_fail++; $display("FAIL rand_mul[%0d]: got cycles=%0d done=%b early=%b expected %0d/1/0", i, cyc, de, dearly, MUL_N); end
          hi_m = p[63:32]; lo_m = p[31:0];
        end
        5: begin
          a = $urandom; b = $urandom_range(1, 100000);
          run_op(FN_DIVU, {a % b, a / b}, cyc, de, dearly);
          n_checks++; if (cyc != DIV_N || de !== 1'b1 || dearly !== 1'b0) begin n_fail++; $display("FAIL rand_div[%0d]: got cycles=%0d done=%b early=%b expected %0d/1/0", i, cyc, de, dearly, DIV_N); end
          hi_m = a % b; lo_m = a / b;
        end
        default: begin
          issue(6'd0 + 6'($urandom_range(0, 15)), $urandom);
          n_checks++; if (data_out !== dout_m || busy !== 1'b0) begin n_fail++; $display("FAIL rand_noop[%0d]: got dout=%h busy=%b expected %h/0", i, data_out, busy, dout_m); end
        end
      endcase
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_div_basic();
    test_mul();
    test_mt_mf();
    test_mt_during_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

HI/LO result register and sequencing controller that sits directly downstream of the 32-bit multiplier and divider in the ALU. It launches a MULTU/DIVU operation and counts the fixed iteration latency of the selected unit. It then latches the unit's 64-bit result into the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. While an operation is in flight it asserts `busy` so the control unit stalls.

## Interface
- `MUL_CYCLES`, default 32: cycles from MULTU launch to multiplier result valid; minimum 1.
- `DIV_CYCLES`, default 32: cycles from DIVU launch to divider result valid; minimum 1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `Signal`  in  6  function code: MFHI=16, MTHI=17, MFLO=18, MTLO=19, MULTU=25, DIVU=27; all other codes are no-ops.
- `start`  in  1  qualifies `Signal` for one cycle.
- `dataIn`  in  32  source operand for MTHI/MTLO.
- `mulOut`  in  64  multiplier result: {product_hi, product_lo}.
- `divOut`  in  64  divider result: {remainder, quotient}.
- `dataOut`  out  32  registered MFHI/MFLO read data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse on the edge HI/LO are loaded from a unit.

## Operation
- Registers: HI[31:0], LO[31:0], state, cnt (width = clog2 of max(MUL_CYCLES, DIV_CYCLES)), dataOut.
- States:
  - IDLE
  - WAIT_MUL
  - WAIT_DIV
- Reset: state=IDLE, cnt=0, HI=LO=0, dataOut=0, busy=0, done=0. Reset overrides every other input, including mid-operation; an in-flight result is discarded.
- Commands are accepted only in IDLE with start=1:
  - MULTU: go to WAIT_MUL, cnt←MUL_CYCLES-1.
  - DIVU: go to WAIT_DIV, cnt←DIV_CYCLES-1.
  - MTHI: HI←dataIn.
  - MTLO: LO←dataIn.
  - MFHI: dataOut←HI.
  - MFLO: dataOut←LO.
  - Other codes: no state change.
- In WAIT_x with cnt≠0: cnt←cnt-1.
- In WAIT_x with cnt=0:
  - HI←out[63:32], LO←out[31:0], where out is mulOut for WAIT_MUL and divOut for WAIT_DIV.
  - done←1, state←IDLE.
  - For DIVU this gives HI=remainder, LO=quotient.
- start while busy: ignored entirely, including MF/MT commands. The control unit must hold the instruction until busy=0.
- MFHI/MFLO in the same cycle as done=1 is accepted (state is IDLE) and reads the newly loaded value.
- No divide-by-zero check: whatever divOut presents is latched unchanged.
- busy = (state≠IDLE), decoded from registered state.
- done is registered and clears to 0 on the following edge.
- dataOut holds its value until the next accepted MFHI/MFLO.

## Timing
- Launch sampled at edge 0. busy=1 after edge 0.
- Result latched at edge N, with N=MUL_CYCLES or DIV_CYCLES. After edge N: busy=0, done=1, HI/LO valid.
- For N=1, the latch happens at edge 1 (cnt loaded 0).
- Back-to-back: a new launch is accepted at edge N+1 at the earliest.
- MFHI/MFLO: 1-cycle latency (dataOut valid after the accepting edge).
- MTHI/MTLO: visible to an MF* at the next accepted edge.
- The upstream unit must hold its result stable at edge N. hilo_ctrl samples mulOut/divOut only on that edge.

## Structure
- A shared ALU package holds:
  - function-code constants: FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULTU, FN_DIVU (same values as the divider's codes).
  - the state enum: ST_IDLE, ST_WAIT_MUL, ST_WAIT_DIV.
- One sub-module, `latency_counter`: loadable down-counter with load value, enable and zero flag, reused by both wait states.
- HI/LO registers, FSM and read mux stay in the top.

## Test plan
- Reset then MFHI, MFLO → dataOut=0 both times; busy=0, done=0.
- DIVU, divOut={32'd2,32'd14} (100/7), DIV_CYCLES=32 → busy high for exactly 32 cycles; done pulse after edge 32; then MFHI→2, MFLO→14.
- MULTU, mulOut=64'h0000_0001_FFFF_FFFE (0xFFFFFFFF×2) → after MUL_CYCLES: HI=1, LO=0xFFFFFFFE.
- MTHI 0xDEADBEEF, MTLO 0x12345678, then MFHI, MFLO → 0xDEADBEEF, 0x12345678. MTLO during busy → LO unchanged after the operation completes.
- DIVU launched, reset asserted at cycle 10 → state IDLE, HI=LO=0, no done pulse, next DIVU completes normally.
- DIVU, then MFLO issued in the done cycle → dataOut = new quotient. A second DIVU in the done cycle → accepted, busy for another DIV_CYCLES.
